// File: rtl/peripheral_msi_slave_arbiter_tl.sv
// Per-slave arbiter for the multi-layer MSI interconnect: priority grant with round-robin tie-break,
// handover only at the owner's switch point. Optional starvation guard: MSI_ARB_STARVATION_GUARD_EN.
module peripheral_msi_slave_arbiter_tl #(
  parameter int unsigned MASTERS      = 5,
  parameter int unsigned MASTER_BITS  = (MASTERS > 1) ? $clog2(MASTERS) : 1,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [MASTERS-1:0]       mst_req,
  input  logic [3*MASTERS-1:0]     mst_priority,
  input  logic [MASTERS-1:0]       mst_can_switch,
  input  logic                     slv_HREADY,
  output logic [MASTERS-1:0]       master_granted,
  output logic [MASTER_BITS-1:0]   owner_idx,
  output logic                     bus_busy
);

  localparam int unsigned PRI_W = 3;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                 state;
  logic [MASTER_BITS-1:0] rr_ptr;
  logic [PRI_W-1:0]       max_pri;
  logic [MASTERS-1:0]     cand;
  logic [MASTERS-1:0]     scan_vec;
  logic [MASTER_BITS:0]   scan_res;
  logic                   win_valid;
  logic [MASTER_BITS-1:0] win_idx;
  logic                   switch_pt;

  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  // First set bit of vec strictly after ptr, wrapping; MSB of result flags a hit
  function automatic logic [MASTER_BITS:0] first_after(input logic [MASTERS-1:0] vec,
                                                        input logic [MASTER_BITS-1:0] ptr);
    logic [MASTER_BITS:0] res;
    int idx;
    res = '0;
    for (int k = int'(MASTERS); k > 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(MASTERS)) idx -= int'(MASTERS);
      if (vec[idx]) res = {1'b1, MASTER_BITS'(idx)};
    end
    return res;
  endfunction

  // Highest requested priority and the requesters sitting at it
  always_comb begin
    max_pri = '0;
    cand    = '0;
    for (int i = 0; i < int'(MASTERS); i++) begin
      if (mst_req[i] && (mst_priority[i*PRI_W +: PRI_W] > max_pri))
        max_pri = mst_priority[i*PRI_W +: PRI_W];
    end
    for (int i = 0; i < int'(MASTERS); i++) begin
      cand[i] = mst_req[i] && (mst_priority[i*PRI_W +: PRI_W] == max_pri);
    end
  end

  assign switch_pt = (state == GRANTED) && mst_can_switch[owner_idx] && slv_HREADY;

`ifdef MSI_ARB_STARVATION_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]   starve_cnt;
  logic [MASTERS-1:0] waiting;
  logic               starve_mode;

  // In GRANTED the grant vector is the owner's one-hot, so this is every non-owner requester
  assign waiting     = mst_req & ~master_granted;
  assign starve_mode = (state == GRANTED) && (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Starved: ignore priority and skip the owner whenever anyone else is asking
  always_comb begin
    scan_vec = cand;
    if (starve_mode) scan_vec = (waiting != '0) ? waiting : mst_req;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      starve_cnt <= '0;
    end else if (state != GRANTED) begin
      starve_cnt <= '0;
    end else if (switch_pt && (starve_mode || (win_valid && (win_idx != owner_idx)))) begin
      starve_cnt <= '0;
    end else if ((waiting != '0) && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign scan_vec = cand;
`endif

  assign scan_res  = first_after(scan_vec, rr_ptr);
  assign win_valid = scan_res[MASTER_BITS];
  assign win_idx   = scan_res[MASTER_BITS-1:0];

  // Grant FSM; every output is registered and changes on the deciding edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state          <= IDLE;
      master_granted <= '0;
      owner_idx      <= '0;
      rr_ptr         <= MASTER_BITS'(MASTERS - 1);
      bus_busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          master_granted <= '0;
          if (win_valid) begin
            state          <= GRANTED;
            master_granted <= MASTERS'(1) << win_idx;
            owner_idx      <= win_idx;
            rr_ptr         <= win_idx;
            bus_busy       <= 1'b1;
          end
        end
        GRANTED: begin
          if (switch_pt) begin
            if (win_valid) begin
              master_granted <= MASTERS'(1) << win_idx;
              owner_idx      <= win_idx;
              rr_ptr         <= win_idx;
            end else begin
              state          <= IDLE;
              master_granted <= '0;
              bus_busy       <= 1'b0;
            end
          end
        end
        default: begin
          state          <= IDLE;
          master_granted <= '0;
          bus_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
